// File: rtl/exc_pkg.sv
// exc_pkg: shared state encoding and cause codes for the exception sequencer
package exc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RAISE, S_HANDLER} state_t;
  localparam logic [3:0] EST_NONE = 4'd0;
  localparam logic [3:0] EST_BADOP = 4'd1;
  localparam logic [3:0] EST_IRQ_BASE = 4'd2;
  function automatic logic [3:0] irq_code(input logic [3:0] i);
    return i + EST_IRQ_BASE;
  endfunction
endpackage

// File: rtl/exc_sequencer_irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder over eligible irq requests
//   req   in  NIRQ  pend & ~mask
//   valid out 1     any request present
//   idx   out 4     lowest set index
module irq_prio_enc #(parameter int NIRQ = 4) (
  input  logic [NIRQ-1:0] req,
  output logic            valid,
  output logic [3:0]      idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) if (req[i]) idx = 4'(i);
  end
endmodule

// File: rtl/exc_sequencer.sv
// exc_sequencer: picks badop/irq causes by priority and drives datapath Exc/EStatus
//   clk, reset (sync, active-low); badop, irq, ERet, ExcAck, mask_we, mask_wdata in
//   Exc, EStatus, busy, fault registered out; irq_ack decoded one-hot pulse out
module exc_sequencer import exc_pkg::*; #(
  parameter int NIRQ = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            badop,
  input  logic [NIRQ-1:0] irq,
  input  logic            ERet,
  input  logic            ExcAck,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic [NIRQ-1:0] irq_ack,
  output logic            busy,
  output logic            fault
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_n;
  logic [NIRQ-1:0] pend, mask, irq_q;
  logic [CW-1:0] cnt;
  logic [3:0] idx, sel_idx, est_n;
  logic sel_valid, timeout, fault_n;
  irq_prio_enc #(.NIRQ(NIRQ)) u_enc (.req(pend & ~mask), .valid(sel_valid), .idx(sel_idx));
  // cnt counts completed RAISE cycles, so the last allowed cycle is ACK_TIMEOUT-1
  assign timeout = cnt == CW'(ACK_TIMEOUT - 1);
  always_comb begin
    state_n = state;
    est_n = EStatus;
    irq_ack = '0;
    fault_n = fault | (badop && state != S_IDLE);
    case (state)
      S_IDLE:
        if (badop || sel_valid) begin
          state_n = S_RAISE;
          est_n = badop ? EST_BADOP : irq_code(sel_idx);
        end
      S_RAISE:
        if (ExcAck) begin
          state_n = S_HANDLER;
          irq_ack = EStatus == EST_BADOP ? '0 : NIRQ'(1) << idx;
        end else if (timeout) begin
          state_n = S_IDLE;
          est_n = EST_NONE;
          fault_n = 1'b1;
        end
      S_HANDLER:
        if (ERet) begin
          state_n = S_IDLE;
          est_n = EST_NONE;
        end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      pend <= '0;
      mask <= '0;
      irq_q <= '0;
      cnt <= '0;
      idx <= '0;
      Exc <= 1'b0;
      EStatus <= EST_NONE;
      busy <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      // a new edge beats the clear from a same-cycle acknowledge
      pend <= (pend & ~irq_ack) | (irq & ~irq_q);
      irq_q <= irq;
      if (mask_we) mask <= mask_wdata;
      cnt <= state == S_RAISE ? cnt + 1'b1 : '0;
      if (state == S_IDLE) idx <= sel_idx;
      Exc <= state_n == S_RAISE;
      EStatus <= est_n;
      busy <= state_n != S_IDLE;
      fault <= fault_n;
    end
  end
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed test-plan checks plus random stimulus against a behavioural model
module tb_exc_sequencer;
  localparam int NIRQ = 4;
  localparam int T = 15;
  logic clk = 0, reset = 0, badop = 0, ERet = 0, ExcAck = 0, mask_we = 0;
  logic [NIRQ-1:0] irq = '0, mask_wdata = '0;
  logic Exc, busy, fault;
  logic [3:0] EStatus;
  logic [NIRQ-1:0] irq_ack;
  int n_tests = 0, n_fail = 0;
  exc_sequencer #(.NIRQ(NIRQ), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .badop(badop), .irq(irq), .ERet(ERet), .ExcAck(ExcAck),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .Exc(Exc), .EStatus(EStatus),
    .irq_ack(irq_ack), .busy(busy), .fault(fault)
  );
  always #5 clk = ~clk;
  bit ready = 0, m_raise = 0, m_hand = 0, m_fault = 0;
  int m_cause = 0, m_high = 0;
  bit [NIRQ-1:0] m_pend = '0, m_mask = '0, m_prev = '0;
  function automatic bit [NIRQ-1:0] exp_ack();
    return (m_raise && ExcAck && m_cause != 1) ? NIRQ'(1 << (m_cause - 2)) : '0;
  endfunction
  always @(posedge clk) begin
    bit [NIRQ-1:0] served, rise;
    int win;
    ready = 1;
    served = exp_ack();
    rise = irq & ~m_prev;
    if (!reset) begin
      m_raise = 0; m_hand = 0; m_fault = 0; m_cause = 0; m_high = 0;
      m_pend = '0; m_mask = '0; m_prev = '0;
    end else begin
      if (badop && (m_raise || m_hand)) m_fault = 1;
      if (m_raise) begin
        if (ExcAck) begin m_raise = 0; m_hand = 1; end
        else if (m_high == T) begin m_raise = 0; m_fault = 1; m_cause = 0; end
        else m_high++;
      end else if (m_hand) begin
        if (ERet) begin m_hand = 0; m_cause = 0; end
      end else begin
        win = -1;
        for (int i = NIRQ - 1; i >= 0; i--) if (m_pend[i] && !m_mask[i]) win = i;
        if (badop) begin m_raise = 1; m_cause = 1; m_high = 1; end
        else if (win >= 0) begin m_raise = 1; m_cause = win + 2; m_high = 1; end
      end
      m_pend = (m_pend & ~served) | rise;
      m_prev = irq;
      if (mask_we) m_mask = mask_wdata;
    end
  end
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask
  always @(negedge clk) if (ready) begin
    check("model Exc", 32'(Exc), 32'(m_raise));
    check("model EStatus", 32'(EStatus), 32'(m_cause));
    check("model busy", 32'(busy), 32'(m_raise | m_hand));
    check("model fault", 32'(fault), 32'(m_fault));
    check("model irq_ack", 32'(irq_ack), 32'(exp_ack()));
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset();
    reset = 0; badop = 0; ERet = 0; ExcAck = 0; mask_we = 0; irq = '0;
    step(2);
    reset = 1;
  endtask
  int hi;
  int ack_pct;
  initial begin
    irq = 4'b1111;
    step(3);
    check("reset Exc", 32'(Exc), 0);
    check("reset EStatus", 32'(EStatus), 0);
    check("reset busy", 32'(busy), 0);
    check("reset fault", 32'(fault), 0);
    check("reset irq_ack", 32'(irq_ack), 0);
    reset = 1;
    step(2);
    check("held irq Exc", 32'(Exc), 1);
    check("held irq EStatus", 32'(EStatus), 4'b0010);
    ExcAck = 1; #1;
    check("held irq ack", 32'(irq_ack), 4'b0001);
    step; ExcAck = 0;
    do_reset();
    irq = 4'b0110;
    step(2);
    check("prio EStatus", 32'(EStatus), 4'b0011);
    ExcAck = 1; #1;
    check("prio ack1", 32'(irq_ack), 4'b0010);
    step; ExcAck = 0; ERet = 1;
    step; ERet = 0;
    check("eret EStatus", 32'(EStatus), 0);
    check("eret busy", 32'(busy), 0);
    step;
    check("second EStatus", 32'(EStatus), 4'b0100);
    ExcAck = 1; #1;
    check("prio ack2", 32'(irq_ack), 4'b0100);
    step; ExcAck = 0;
    do_reset();
    irq = 4'b0001;
    step; badop = 1;
    step; badop = 0;
    check("badop EStatus", 32'(EStatus), 4'b0001);
    ExcAck = 1; #1;
    check("badop no ack", 32'(irq_ack), 0);
    step; ExcAck = 0; ERet = 1;
    step; ERet = 0;
    step;
    check("irq0 after badop", 32'(EStatus), 4'b0010);
    do_reset();
    mask_we = 1; mask_wdata = 4'b0001;
    step; mask_we = 0; irq = 4'b0001;
    step(3);
    check("masked Exc", 32'(Exc), 0);
    mask_we = 1; mask_wdata = 4'b0000;
    step; mask_we = 0;
    check("unmask delay", 32'(Exc), 0);
    step;
    check("unmask Exc", 32'(Exc), 1);
    check("unmask EStatus", 32'(EStatus), 4'b0010);
    hi = 0;
    for (int k = 0; k < 40 && Exc; k++) begin hi++; step; end
    check("timeout length", 32'(hi), 15);
    check("timeout Exc", 32'(Exc), 0);
    check("timeout EStatus", 32'(EStatus), 0);
    check("timeout fault", 32'(fault), 1);
    step(5);
    check("fault sticky", 32'(fault), 1);
    do_reset();
    step;
    check("fault cleared", 32'(fault), 0);
    badop = 1;
    step; badop = 0; ExcAck = 1;
    step; ExcAck = 0; badop = 1;
    step; badop = 0;
    check("handler badop fault", 32'(fault), 1);
    check("handler badop Exc", 32'(Exc), 0);
    irq = 4'b1000;
    step(3);
    check("no nesting Exc", 32'(Exc), 0);
    check("no nesting busy", 32'(busy), 1);
    ERet = 1;
    step; ERet = 0;
    check("handler eret EStatus", 32'(EStatus), 0);
    step;
    check("irq3 EStatus", 32'(EStatus), 4'b0101);
    do_reset();
    ack_pct = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) ack_pct = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(10, 70);
      reset = $urandom_range(0, 299) != 0;
      badop = $urandom_range(0, 15) == 0;
      ERet = $urandom_range(0, 7) == 0;
      ExcAck = $urandom_range(0, 99) < ack_pct;
      mask_we = $urandom_range(0, 19) == 0;
      mask_wdata = NIRQ'($urandom) & NIRQ'($urandom);
      for (int i = 0; i < NIRQ; i++) if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
      step;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
